// File: rtl/swu_rom_stream_ctrl.sv
// ---------------------------------------------------------------------------
// swu_rom_stream_ctrl
//
// Reads DEPTH words (addr 0..DEPTH-1) from a 1-cycle-latency synchronous ROM
// and streams them to a valid/ready consumer. A 2-entry buffer absorbs the
// ROM latency so a word per cycle flows while out_ready stays high.
//
// Optional build macro: SWU_ROM_LOOP_EN
//   defined   - the address counter wraps after DEPTH-1 and streaming repeats
//               until abort or reset; done pulses after every out_last beat.
//   undefined - a single pass per start.
//
// Ports
//   clk        clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   start      1-cycle pulse, begins a run (IDLE only)
//   abort      synchronous abort: flush buffer and in-flight read, go IDLE
//   busy       high while a run is in progress
//   done       1-cycle pulse after the out_last handshake
//   rom_en     ROM read enable
//   rom_addr   ROM read address
//   rom_data   ROM read data, valid the cycle after rom_en
//   out_valid  out_data valid
//   out_ready  consumer ready
//   out_data   streamed word
//   out_idx    ROM address of out_data
//   out_last   marks the word from addr DEPTH-1
// ---------------------------------------------------------------------------
module swu_rom_stream_ctrl #(
    parameter int DEPTH = 29,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] fl_addr_q, fl_addr_d;
    logic          done_q, done_d;

    // 2-entry FIFO
    logic [DW-1:0] buf_data_q [2];
    logic [AW-1:0] buf_idx_q  [2];
    logic [1:0]    buf_last_q;
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    occ_q;

    logic          pop;
    logic          push;
    logic [1:0]    wr_en;
    logic [2:0]    ahead;
    logic          head_last;

    assign head_last = buf_last_q[rd_ptr_q];
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = out_valid ? buf_data_q[rd_ptr_q] : '0;
    assign out_idx   = out_valid ? buf_idx_q[rd_ptr_q]  : '0;
    assign out_last  = out_valid & head_last;

    assign pop  = out_valid & out_ready;
    // A read returning in the abort cycle (or the one after) is dropped.
    assign push = inflight_q & ~abort;

    // Words already committed downstream of the ROM after this cycle's pop;
    // a new read is only issued if it still fits in the 2-entry buffer.
    assign ahead  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rom_en = (state_q == S_FETCH) && (ahead < 3'd2);

    assign rom_addr = cnt_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
    end

    // Next-state / counter logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inflight_d = rom_en & ~abort;
        fl_addr_d  = rom_en ? cnt_q : fl_addr_q;
        done_d     = pop & head_last & ~abort;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rom_en) begin
                    // Compare before increment so DEPTH == 2^AW never wraps.
                    if (cnt_q == LAST_ADDR) begin
`ifdef SWU_ROM_LOOP_EN
                        cnt_d = '0;
`else
                        state_d = S_DRAIN;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            fl_addr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            fl_addr_q  <= fl_addr_d;
            done_q     <= done_d;
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop keep occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (abort) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            occ_q    <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_idx_q[i]  <= '0;
            end
            buf_last_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i]) begin
                    buf_data_q[i] <= rom_data;
                    buf_idx_q[i]  <= fl_addr_q;
                    buf_last_q[i] <= (fl_addr_q == LAST_ADDR);
                end
            end
        end
    end

endmodule
